// File: rtl/fsm_resp_capture_pkg.sv
// Shared types and constants for the FSM response capture block.
// Records are {ts, y}: timestamp in the MSBs, observed vector in the LSBs.
package fsm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  localparam int Y_LSB = 0;

  function automatic int ts_lsb(input int out_w);
    return out_w;
  endfunction

  function automatic logic [31:0] misr_step(
    input logic [31:0] s,
    input logic [31:0] d
  );
    logic [31:0] fb;
    fb = s[31] ? MISR_POLY : 32'h0;
    return {s[30:0], 1'b0} ^ fb ^ d;
  endfunction

endpackage

// File: rtl/fsm_resp_capture_if.sv
// Record drain handshake: the capture block is the master (source),
// the harness or scan-out logic is the slave (sink).
interface fsm_resp_capture_if #(
  parameter int W = 38
) ();

  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/fsm_resp_capture_fifo.sv
// Show-ahead synchronous FIFO; rdata is the head entry, zero when empty.
// A push into a full FIFO lands only if a pop happens in the same cycle.
module capture_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fsm_resp_capture.sv
// Observes an FSM output vector, arms on a masked trigger, logs changes.
// Optional MISR signature on sig when CAPTURE_MISR_EN is defined.
module fsm_resp_capture
  import fsm_capture_pkg::*;
#(
  parameter int OUT_W = 22,
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [OUT_W-1:0]       trig_mask,
  input  logic [OUT_W-1:0]       trig_val,
  input  logic [OUT_W-1:0]       y_in,
  fsm_resp_capture_if.master     rd,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            sig
);

  localparam int RW     = TS_W + OUT_W;
  localparam int TS_LSB = ts_lsb(OUT_W);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ARMED   = ARMED;
  localparam logic [1:0] S_CAPTURE = CAPTURE;
  localparam logic [1:0] S_DONE    = DONE;

  localparam logic [TS_W-1:0] TS_MAX = '1;

  logic [1:0]       state;
  logic [TS_W-1:0]  ts;
  logic [OUT_W-1:0] y_prev;
  logic             ovf;

  logic             hit;
  logic             chg;
  logic             pop;
  logic             room;
  logic             push;
  logic             lost;
  logic             trig;
  logic [RW-1:0]    wdata;
  logic [RW-1:0]    rdata;
  logic             full;
  logic             empty;

  capture_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign rd.rd_valid = !empty;
  assign rd.rd_data  = rdata;

  assign busy     = (state == S_ARMED) || (state == S_CAPTURE);
  assign done     = (state == S_DONE);
  assign overflow = ovf;

  assign hit  = ((y_in ^ trig_val) & trig_mask) == '0;
  assign chg  = (y_in != y_prev);
  assign pop  = rd.rd_valid && rd.rd_ready;
  assign room = !full || pop;
  assign trig = (state == S_ARMED) && !stop && hit;

  always_comb begin
    push  = 1'b0;
    lost  = 1'b0;
    wdata = '0;
    wdata[Y_LSB +: OUT_W] = y_in;
    unique case (1'b1)
      (state == S_ARMED): begin
        push = trig && room;
        lost = trig && !room;
      end
      (state == S_CAPTURE): begin
        wdata[TS_LSB +: TS_W] = ts;
        push = chg && room;
        lost = chg && !room;
      end
      default: ;
    endcase
  end

  // A record that cannot be stored ends the run; the log is incomplete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      ts     <= '0;
      y_prev <= '0;
      ovf    <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE),
        (state == S_DONE): begin
          if (start) begin
            state <= S_ARMED;
            ts    <= '0;
            ovf   <= 1'b0;
          end
        end
        (state == S_ARMED): begin
          if (stop) begin
            state <= S_DONE;
          end else if (hit) begin
            ts     <= TS_W'(1);
            y_prev <= y_in;
            if (lost) begin
              ovf   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_CAPTURE;
            end
          end
        end
        (state == S_CAPTURE): begin
          if (ts != TS_MAX) ts <= ts + 1'b1;
          if (push) y_prev <= y_in;
          if (lost) begin
            ovf   <= 1'b1;
            state <= S_DONE;
          end else if (stop) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CAPTURE_MISR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= '0;
    end else if (trig) begin
      sig <= '0;
    end else if (state == S_CAPTURE) begin
      sig <= misr_step(sig, 32'(y_in));
    end
  end
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_fsm_resp_capture.sv
// Scoreboard bench for fsm_resp_capture: a queue-based reference model
// predicts records; a monitor checks every drained record in order.
module tb_fsm_resp_capture;

  localparam int OUT_W = 22;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
  localparam int RW    = TS_W + OUT_W;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_CAP  = 2;
  localparam int M_DONE = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [OUT_W-1:0] trig_mask = '0;
  logic [OUT_W-1:0] trig_val = '0;
  logic [OUT_W-1:0] y_in = '0;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       count;
  logic [31:0]      sig;

  fsm_resp_capture_if #(.W(RW)) rd ();

  fsm_resp_capture #(
    .OUT_W (OUT_W),
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .trig_mask (trig_mask),
    .trig_val  (trig_val),
    .y_in      (y_in),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .count     (count),
    .sig       (sig)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total = 0;
  int          m_mode = M_IDLE;
  logic [15:0] m_ts = '0;
  logic [21:0] m_prev = '0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_sig = '0;
  logic [37:0] q[$];
  int          pend = 0;
  bit          sig_chk = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Reference model: one call describes what the next clock edge does.
  task automatic model_step(input bit s, input bit p,
                            input logic [21:0] y, input bit r);
    bit pop_now;
    bit room;
    pop_now = r && (q.size() > 0);
    room    = (q.size() < DEPTH) || pop_now;
    pend    = 0;
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (s) begin
          m_mode = M_ARM;
          m_ts   = 0;
          m_ovf  = 0;
        end
      end
      M_ARM: begin
        if (p) begin
          m_mode = M_DONE;
        end else if ((y & trig_mask) == (trig_val & trig_mask)) begin
          m_sig  = 0;
          m_prev = y;
          m_ts   = 1;
          if (room) begin
            q.push_back({16'h0, y});
            pend   = 1;
            m_mode = M_CAP;
          end else begin
            m_ovf  = 1;
            m_mode = M_DONE;
          end
        end
      end
      default: begin
`ifdef CAPTURE_MISR_EN
        m_sig = (m_sig << 1) ^ (m_sig[31] ? 32'h04C11DB7 : 32'h0)
                ^ {10'h0, y};
`endif
        if (y != m_prev) begin
          if (room) begin
            q.push_back({m_ts, y});
            pend   = 1;
            m_prev = y;
          end else begin
            m_ovf  = 1;
            m_mode = M_DONE;
          end
        end
        if (m_mode == M_CAP && p) m_mode = M_DONE;
        if (m_ts != 16'hFFFF) m_ts = m_ts + 16'd1;
      end
    endcase
  endtask

  task automatic cyc(input bit s, input bit p,
                     input logic [21:0] y, input bit r);
    bit bz;
    @(negedge clk);
    #1;
    bz = (m_mode == M_ARM) || (m_mode == M_CAP);
    check("count", 64'(count), 64'(q.size()));
    check("busy", 64'(busy), 64'(bz));
    check("done", 64'(done), 64'(m_mode == M_DONE));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("sig", 64'(sig), 64'(m_sig));
    if (sig_chk) begin
`ifdef CAPTURE_MISR_EN
      check("sig_misr", 64'(sig), 64'h3);
`else
      check("sig_misr", 64'(sig), 64'h0);
`endif
      sig_chk = 1'b0;
    end
    start       = s;
    stop        = p;
    y_in        = y;
    rd.rd_ready = r;
    model_step(s, p, y, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst         = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    y_in        = '0;
    rd.rd_ready = 1'b0;
    q.delete();
    pend   = 0;
    m_mode = M_IDLE;
    m_ts   = 0;
    m_prev = 0;
    m_ovf  = 0;
    m_sig  = 0;
    #1;
    check("rst_count", 64'(count), 64'h0);
    check("rst_valid", 64'(rd.rd_valid), 64'h0);
    check("rst_data", 64'(rd.rd_data), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_ovf", 64'(overflow), 64'h0);
    check("rst_sig", 64'(sig), 64'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: after inputs settle, any accepted head record is scored.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("rd_valid", 64'(rd.rd_valid),
              64'((q.size() - pend) > 0));
        if (!rd.rd_valid) begin
          check("rd_data_empty", 64'(rd.rd_data), 64'h0);
        end else if (rd.rd_ready) begin
          if (q.size() == 0) begin
            total++;
            $display("FAIL rd_data: got %0h required no record",
                     rd.rd_data);
          end else begin
            check("rd_data", 64'(rd.rd_data), 64'(q.pop_front()));
          end
        end
      end
    end
  end

  logic [21:0] pool [4];
  logic [21:0] yr;

  initial begin
    rd.rd_ready = 1'b0;
    do_reset();

    // reset in the middle of a capture holding three records
    trig_mask = '0;
    cyc(1, 0, 22'h1, 0);
    cyc(0, 0, 22'h1, 0);
    cyc(0, 0, 22'h2, 0);
    cyc(0, 0, 22'h3, 0);
    cyc(0, 0, 22'h3, 0);
    check("pre_rst_count", 64'(count), 64'h3);
    do_reset();
    cyc(0, 0, 22'h0, 1);

    // masked full-vector trigger, then one later change
    trig_mask = 22'h3FFFFF;
    trig_val  = 22'h000802;
    cyc(1, 0, 22'h0, 1);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 22'h5, 1);
    for (int i = 5; i <= 8; i++) cyc(0, 0, 22'h802, 1);
    for (int i = 9; i <= 11; i++) cyc(0, 0, 22'h1000, 1);
    cyc(0, 1, 22'h1000, 1);
    repeat (3) cyc(0, 0, 22'h1000, 1);

    // zero mask: immediate trigger, constant input
    trig_mask = '0;
    cyc(1, 0, 22'h123, 1);
    repeat (5) cyc(0, 0, 22'h123, 1);
    cyc(0, 1, 22'h123, 1);
    repeat (2) cyc(0, 0, 22'h123, 1);

    // fill eight records with no reads, ninth change overflows
    cyc(1, 0, 22'h10, 0);
    cyc(0, 0, 22'h10, 0);
    for (int i = 1; i <= 7; i++) cyc(0, 0, 22'(22'h10 + i), 0);
    cyc(0, 0, 22'h18, 0);
    cyc(0, 0, 22'h18, 0);
    check("ovf_count", 64'(count), 64'h8);
    repeat (10) cyc(0, 0, 22'h18, 1);

    // full FIFO, read and change in the same cycle
    cyc(1, 0, 22'h20, 0);
    cyc(0, 0, 22'h20, 0);
    for (int i = 1; i <= 7; i++) cyc(0, 0, 22'(22'h20 + i), 0);
    cyc(0, 0, 22'h30, 1);
    cyc(0, 1, 22'h30, 0);
    check("full_rw_count", 64'(count), 64'h8);
    repeat (10) cyc(0, 0, 22'h30, 1);

    // signature over two capture cycles of a constant one
    cyc(1, 0, 22'h1, 1);
    cyc(0, 0, 22'h1, 1);
    cyc(0, 0, 22'h1, 1);
    cyc(0, 0, 22'h1, 1);
    sig_chk = 1'b1;
    cyc(0, 1, 22'h1, 1);
    repeat (2) cyc(0, 0, 22'h1, 1);

    // randomized traffic
    trig_mask = 22'h00000F;
    trig_val  = 22'h000005;
    pool[0] = 22'h000005;
    pool[1] = 22'h00000F;
    pool[2] = 22'h000105;
    pool[3] = 22'h02A0A0;
    yr = pool[0];
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) yr = pool[$urandom_range(0, 3)];
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
          yr, $urandom_range(0, 1) == 1);
    end
    cyc(0, 1, yr, 1);
    repeat (12) cyc(0, 0, yr, 1);

    // timestamp saturates instead of wrapping
    trig_mask = '0;
    cyc(1, 0, 22'h3AAAA, 1);
    repeat (65540) cyc(0, 0, 22'h3AAAA, 1);
    cyc(0, 0, 22'h15555, 1);
    cyc(0, 1, 22'h15555, 1);
    repeat (4) cyc(0, 0, 22'h15555, 1);

    check("final_drain", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
